// File: rtl/pipeline_control_unit.sv
// Control and hazard unit for a 5-stage pipeline: ID decode, ID/EX, EX/MEM and MEM/WB
// control registers, EX forwarding selects, load-use/branch stalls and branch redirect.
module pipeline_control_unit #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] instrD,
  input  logic            eqD,
  output logic            regWrite,
  output logic            regDst,
  output logic            aluSrcB,
  output logic [2:0]      aluControl,
  output logic            memWrite,
  output logic            mem2Reg,
  output logic            pcSrc,
  output logic [1:0]      fad,
  output logic [1:0]      fbd,
  output logic            flush,
  output logic            stall
);

  localparam int unsigned AW = 3;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [AW-1:0] ALU_ADD = 3'b010;
  localparam logic [AW-1:0] ALU_SUB = 3'b110;
  localparam logic [AW-1:0] ALU_AND = 3'b000;
  localparam logic [AW-1:0] ALU_OR  = 3'b001;
  localparam logic [AW-1:0] ALU_SLT = 3'b111;

  typedef struct packed {
    logic          reg_write;
    logic          mem2reg;
    logic          mem_write;
    logic          alu_src_b;
    logic          reg_dst;
    logic [AW-1:0] alu_ctrl;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [RW-1:0] rd;
  } id_ex_t;

  typedef struct packed {
    logic          reg_write;
    logic          mem2reg;
    logic          mem_write;
    logic [RW-1:0] write_reg;
  } ex_mem_t;

  typedef struct packed {
    logic          reg_write;
    logic          mem2reg;
    logic [RW-1:0] write_reg;
  } mem_wb_t;

  logic [5:0]    op_d;
  logic [5:0]    funct_d;
  logic [RW-1:0] rs_d;
  logic [RW-1:0] rt_d;
  logic          branch_d;
  logic          lw_stall;
  logic          br_stall;
  logic [RW-1:0] write_reg_e;
  logic          unused_bits;

  id_ex_t  dec_d;
  id_ex_t  id_ex_d,  id_ex_q;
  ex_mem_t ex_mem_d, ex_mem_q;
  mem_wb_t mem_wb_d, mem_wb_q;

  assign op_d        = instrD[31:26];
  assign funct_d     = instrD[5:0];
  assign rs_d        = instrD[21 +: RW];
  assign rt_d        = instrD[16 +: RW];
  assign unused_bits = ^{instrD[10:6]};

  // ID-stage decode; unknown op/funct fall through to an all-zero nop
  always_comb begin
    dec_d    = '0;
    branch_d = 1'b0;
    dec_d.rs = rs_d;
    dec_d.rt = rt_d;
    dec_d.rd = instrD[11 +: RW];
    case (op_d)
      OP_RTYPE: begin
        case (funct_d)
          6'h20: dec_d.alu_ctrl = ALU_ADD;
          6'h22: dec_d.alu_ctrl = ALU_SUB;
          6'h24: dec_d.alu_ctrl = ALU_AND;
          6'h25: dec_d.alu_ctrl = ALU_OR;
          6'h2A: dec_d.alu_ctrl = ALU_SLT;
          default: dec_d.alu_ctrl = ALU_AND;
        endcase
        if (funct_d inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A}) begin
          dec_d.reg_write = 1'b1;
          dec_d.reg_dst   = 1'b1;
        end
      end
      OP_LW: begin
        dec_d.reg_write = 1'b1;
        dec_d.alu_src_b = 1'b1;
        dec_d.mem2reg   = 1'b1;
        dec_d.alu_ctrl  = ALU_ADD;
      end
      OP_SW: begin
        dec_d.mem_write = 1'b1;
        dec_d.alu_src_b = 1'b1;
        dec_d.alu_ctrl  = ALU_ADD;
      end
      OP_BEQ: begin
        branch_d       = 1'b1;
        dec_d.alu_ctrl = ALU_SUB;
      end
      OP_ADDI: begin
        dec_d.reg_write = 1'b1;
        dec_d.alu_src_b = 1'b1;
        dec_d.alu_ctrl  = ALU_ADD;
      end
      default: dec_d = '0;
    endcase
  end

  // Hazard detection; register 0 never matches
  always_comb begin
    write_reg_e = id_ex_q.reg_dst ? id_ex_q.rd : id_ex_q.rt;
    lw_stall    = id_ex_q.mem2reg && (id_ex_q.rt != '0) &&
                  ((id_ex_q.rt == rs_d) || (id_ex_q.rt == rt_d));
    br_stall    = branch_d &&
                  ((id_ex_q.reg_write && (write_reg_e != '0) &&
                    ((write_reg_e == rs_d) || (write_reg_e == rt_d))) ||
                   (ex_mem_q.mem2reg && (ex_mem_q.write_reg != '0) &&
                    ((ex_mem_q.write_reg == rs_d) || (ex_mem_q.write_reg == rt_d))));
  end

  assign stall = lw_stall | br_stall;
  assign pcSrc = branch_d & eqD & ~stall;
  assign flush = pcSrc;

  function automatic logic [1:0] fwd_sel(input logic [RW-1:0] src,
                                         input logic          wr_m,
                                         input logic [RW-1:0] reg_m,
                                         input logic          wr_w,
                                         input logic [RW-1:0] reg_w);
    if ((src != '0) && wr_m && (reg_m == src))      return 2'b10;
    else if ((src != '0) && wr_w && (reg_w == src)) return 2'b01;
    else                                            return 2'b00;
  endfunction

  assign fad = fwd_sel(id_ex_q.rs, ex_mem_q.reg_write, ex_mem_q.write_reg,
                       mem_wb_q.reg_write, mem_wb_q.write_reg);
  assign fbd = fwd_sel(id_ex_q.rt, ex_mem_q.reg_write, ex_mem_q.write_reg,
                       mem_wb_q.reg_write, mem_wb_q.write_reg);

  // Next-state for the pipeline control registers; a stall injects a bubble into EX
  always_comb begin
    id_ex_d            = stall ? '0 : dec_d;
    ex_mem_d.reg_write = id_ex_q.reg_write;
    ex_mem_d.mem2reg   = id_ex_q.mem2reg;
    ex_mem_d.mem_write = id_ex_q.mem_write;
    ex_mem_d.write_reg = write_reg_e;
    mem_wb_d.reg_write = ex_mem_q.reg_write;
    mem_wb_d.mem2reg   = ex_mem_q.mem2reg;
    mem_wb_d.write_reg = ex_mem_q.write_reg;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      id_ex_q  <= '0;
      ex_mem_q <= '0;
      mem_wb_q <= '0;
    end else begin
      id_ex_q  <= id_ex_d;
      ex_mem_q <= ex_mem_d;
      mem_wb_q <= mem_wb_d;
    end
  end

  assign regDst     = id_ex_q.reg_dst;
  assign aluSrcB    = id_ex_q.alu_src_b;
  assign aluControl = id_ex_q.alu_ctrl;
  assign memWrite   = ex_mem_q.mem_write;
  assign regWrite   = mem_wb_q.reg_write;
  assign mem2Reg    = mem_wb_q.mem2reg;

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Scoreboard bench for pipeline_control_unit: directed instruction streams push
// per-cycle expectations; a negedge monitor pops and compares them.
module tb_pipeline_control_unit;

  localparam int S_RW = 0, S_RDST = 1, S_ASRC = 2, S_ALUC = 3, S_MW = 4, S_M2R = 5,
                 S_PCS = 6, S_FAD = 7, S_FBD = 8, S_FLUSH = 9, S_STALL = 10;

  localparam logic [31:0] NOP    = 32'h0000_0000;
  localparam logic [31:0] ADD3   = 32'h0022_1820; // add $3,$1,$2
  localparam logic [31:0] SUB5   = 32'h0061_2822; // sub $5,$3,$1
  localparam logic [31:0] LW2    = 32'h8C22_0000; // lw $2,0($1)
  localparam logic [31:0] LW3    = 32'h8C23_0000; // lw $3,0($1)
  localparam logic [31:0] ADD4   = 32'h0045_2020; // add $4,$2,$5
  localparam logic [31:0] BEQ12  = 32'h1022_0004; // beq $1,$2
  localparam logic [31:0] BEQ31  = 32'h1061_0004; // beq $3,$1
  localparam logic [31:0] BEQ01  = 32'h1001_0004; // beq $0,$1
  localparam logic [31:0] ADD0   = 32'h0022_0020; // add $0,$1,$2
  localparam logic [31:0] SW67   = 32'hACE6_0004; // sw $6,4($7)
  localparam logic [31:0] ADDI89 = 32'h2128_0005; // addi $8,$9,5
  localparam logic [31:0] ADDI3  = 32'h2063_0005; // addi $3,$3,5
  localparam logic [31:0] AND6   = 32'h0023_3024; // and $6,$1,$3
  localparam logic [31:0] OR7    = 32'h0063_3825; // or $7,$3,$3
  localparam logic [31:0] ADDU   = 32'h0022_1821; // unsupported funct
  localparam logic [31:0] JOP    = 32'h0800_0000; // unsupported op

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instrD;
  logic        eqD;
  logic        regWrite, regDst, aluSrcB, memWrite, mem2Reg, pcSrc, flush, stall;
  logic [2:0]  aluControl;
  logic [1:0]  fad, fbd;

  typedef struct {
    int         cyc;
    int         sig;
    logic [2:0] val;
    string      name;
  } exp_t;

  exp_t sb_q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  pipeline_control_unit #(.XLEN(32), .RW(5)) dut (
    .clk(clk), .rst(rst), .instrD(instrD), .eqD(eqD),
    .regWrite(regWrite), .regDst(regDst), .aluSrcB(aluSrcB), .aluControl(aluControl),
    .memWrite(memWrite), .mem2Reg(mem2Reg), .pcSrc(pcSrc), .fad(fad), .fbd(fbd),
    .flush(flush), .stall(stall)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [2:0] obs(input int s);
    case (s)
      S_RW:    return {2'b00, regWrite};
      S_RDST:  return {2'b00, regDst};
      S_ASRC:  return {2'b00, aluSrcB};
      S_ALUC:  return aluControl;
      S_MW:    return {2'b00, memWrite};
      S_M2R:   return {2'b00, mem2Reg};
      S_PCS:   return {2'b00, pcSrc};
      S_FAD:   return {1'b0, fad};
      S_FBD:   return {1'b0, fbd};
      S_FLUSH: return {2'b00, flush};
      S_STALL: return {2'b00, stall};
      default: return 3'b000;
    endcase
  endfunction

  // Monitor: compare every expectation due in the current cycle
  always @(negedge clk) begin
    logic [2:0] act;
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].cyc == cyc) begin
        act    = obs(sb_q[i].sig);
        checks = checks + 1;
        if (act !== sb_q[i].val) begin
          errors = errors + 1;
          $display("FAIL %s cyc=%0d got=%0d expected=%0d", sb_q[i].name, cyc, act, sb_q[i].val);
        end
        sb_q.delete(i);
      end
    end
  end

  task automatic chk(input int c, input int s, input logic [2:0] v, input string nm);
    exp_t e;
    e.cyc = c; e.sig = s; e.val = v; e.name = nm;
    sb_q.push_back(e);
  endtask

  task automatic drv(input logic [31:0] ins, input logic eq, output int c);
    @(posedge clk);
    #1;
    instrD = ins;
    eqD    = eq;
    c      = cyc;
  endtask

  task automatic nops(input int n);
    int c;
    repeat (n) drv(NOP, 1'b0, c);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int c, c0, d, e, g, h, k, m, p, q, r, s, u, w;
    rst = 1'b0; instrD = NOP; eqD = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b1; c = cyc;
    chk(c, S_RW, 0, "rst_regwrite");  chk(c, S_MW, 0, "rst_memwrite");
    chk(c, S_M2R, 0, "rst_mem2reg");  chk(c, S_ALUC, 0, "rst_aluctrl");
    chk(c, S_STALL, 0, "rst_stall");  chk(c, S_FAD, 0, "rst_fad");
    chk(c, S_PCS, 0, "rst_pcsrc");
    nops(3);

    // ALU-result forwarding from MEM
    drv(ADD3, 1'b0, c);
    chk(c + 1, S_ALUC, 3'b010, "alu_add_ex"); chk(c + 1, S_RDST, 1, "alu_add_rdst");
    chk(c + 2, S_FAD, 2'b10, "alu_fad");      chk(c + 2, S_FBD, 2'b00, "alu_fbd");
    chk(c + 2, S_ALUC, 3'b110, "alu_sub_ex");
    chk(c + 3, S_RW, 1, "alu_add_wb");        chk(c + 3, S_M2R, 0, "alu_add_m2r");
    chk(c + 4, S_RW, 1, "alu_sub_wb");
    drv(SUB5, 1'b0, c);
    chk(c, S_STALL, 0, "alu_nostall");
    nops(4);

    // WB forwarding
    drv(ADD3, 1'b0, c); drv(NOP, 1'b0, c); drv(SUB5, 1'b0, w);
    chk(w + 1, S_FAD, 2'b01, "wb_fad"); chk(w + 1, S_FBD, 2'b00, "wb_fbd");
    chk(w + 1, S_ALUC, 3'b110, "wb_aluctrl");
    nops(4);

    // Load-use stall with one bubble
    drv(LW2, 1'b0, d);
    chk(d, S_STALL, 0, "lu_lw_id_stall");
    chk(d + 1, S_STALL, 1, "lu_stall");       chk(d + 1, S_PCS, 0, "lu_pcsrc");
    chk(d + 2, S_STALL, 0, "lu_stall_clear");
    chk(d + 2, S_ALUC, 0, "lu_bubble_alu");   chk(d + 2, S_RDST, 0, "lu_bubble_rdst");
    chk(d + 2, S_ASRC, 0, "lu_bubble_asrc");
    chk(d + 3, S_FAD, 2'b01, "lu_fad");       chk(d + 3, S_FBD, 2'b00, "lu_fbd");
    chk(d + 3, S_ALUC, 3'b010, "lu_add_ex");
    chk(d + 3, S_RW, 1, "lu_lw_wb");          chk(d + 3, S_M2R, 1, "lu_lw_m2r");
    chk(d + 4, S_RW, 0, "lu_bubble_wb");
    chk(d + 5, S_RW, 1, "lu_add_wb");         chk(d + 5, S_M2R, 0, "lu_add_m2r");
    drv(ADD4, 1'b0, c); drv(ADD4, 1'b0, c);
    nops(4);

    // Branch taken / not taken
    drv(BEQ12, 1'b1, e);
    chk(e, S_PCS, 1, "br_pcsrc");             chk(e, S_FLUSH, 1, "br_flush");
    chk(e, S_STALL, 0, "br_nostall");
    chk(e + 1, S_ALUC, 3'b110, "br_ex_sub");  chk(e + 1, S_RDST, 0, "br_ex_rdst");
    chk(e + 2, S_MW, 0, "br_memwrite");       chk(e + 3, S_RW, 0, "br_regwrite");
    nops(4);
    drv(BEQ12, 1'b0, e);
    chk(e, S_PCS, 0, "brnt_pcsrc");           chk(e, S_FLUSH, 0, "brnt_flush");
    nops(4);

    // Branch stall on ALU producer in EX
    drv(ADD3, 1'b0, c); drv(BEQ31, 1'b1, g);
    chk(g, S_STALL, 1, "bh_stall");           chk(g, S_PCS, 0, "bh_pcsrc_held");
    chk(g, S_FLUSH, 0, "bh_flush_held");
    drv(BEQ31, 1'b1, h);
    chk(h, S_STALL, 0, "bh_stall_clear");     chk(h, S_PCS, 1, "bh_pcsrc");
    chk(h, S_FLUSH, 1, "bh_flush");
    nops(4);

    // $0 destination: no stall, no forward
    drv(ADD0, 1'b0, c); drv(BEQ01, 1'b1, k);
    chk(k, S_STALL, 0, "r0_nostall");         chk(k, S_PCS, 1, "r0_pcsrc");
    chk(k + 1, S_FAD, 2'b00, "r0_fad");
    nops(4);

    // Branch stall on load in MEM
    drv(LW3, 1'b0, c); drv(NOP, 1'b0, c); drv(BEQ31, 1'b1, m);
    chk(m, S_STALL, 1, "blw_stall");          chk(m, S_PCS, 0, "blw_pcsrc_held");
    drv(BEQ31, 1'b1, m);
    chk(m, S_STALL, 0, "blw_stall_clear");    chk(m, S_PCS, 1, "blw_pcsrc");
    nops(4);

    // Operand B forwarding and MEM-over-WB priority
    drv(ADD3, 1'b0, c); drv(AND6, 1'b0, p);
    chk(p + 1, S_FBD, 2'b10, "fb_fbd");       chk(p + 1, S_FAD, 2'b00, "fb_fad");
    chk(p + 1, S_ALUC, 3'b000, "fb_and");
    nops(4);
    drv(ADD3, 1'b0, c); drv(ADDI3, 1'b0, q);
    chk(q + 1, S_FAD, 2'b10, "pr_addi_fad");  chk(q + 1, S_ASRC, 1, "pr_addi_asrc");
    chk(q + 1, S_ALUC, 3'b010, "pr_addi_alu");
    drv(OR7, 1'b0, r);
    chk(r + 1, S_FAD, 2'b10, "pr_fad");       chk(r + 1, S_FBD, 2'b10, "pr_fbd");
    chk(r + 1, S_ALUC, 3'b001, "pr_or");
    nops(4);

    // Store and unsupported encodings
    drv(SW67, 1'b0, s);
    chk(s + 1, S_ASRC, 1, "sw_asrc");         chk(s + 1, S_RDST, 0, "sw_rdst");
    chk(s + 2, S_MW, 1, "sw_memwrite");       chk(s + 3, S_RW, 0, "sw_regwrite");
    drv(ADDU, 1'b0, u);
    chk(u + 1, S_RDST, 0, "bad_funct_rdst");  chk(u + 1, S_ALUC, 0, "bad_funct_alu");
    chk(u + 3, S_RW, 0, "bad_funct_rw");
    drv(JOP, 1'b0, u);
    chk(u + 1, S_ALUC, 0, "bad_op_alu");      chk(u + 3, S_RW, 0, "bad_op_rw");
    nops(4);

    // Reset mid-stream discards everything in flight
    drv(LW2, 1'b0, c0); drv(SW67, 1'b0, c); drv(ADDI89, 1'b0, c);
    rst = 1'b0;
    chk(c, S_ASRC, 1, "mr_pre_asrc");         chk(c, S_ALUC, 3'b010, "mr_pre_alu");
    drv(NOP, 1'b0, c);
    rst = 1'b1;
    chk(c, S_RW, 0, "mr_regwrite");           chk(c, S_MW, 0, "mr_memwrite");
    chk(c, S_M2R, 0, "mr_mem2reg");           chk(c, S_ALUC, 0, "mr_aluctrl");
    chk(c, S_ASRC, 0, "mr_asrc");             chk(c, S_STALL, 0, "mr_stall");
    chk(c + 1, S_RW, 0, "mr_regwrite_next");  chk(c + 1, S_MW, 0, "mr_memwrite_next");
    nops(5);

    if (sb_q.size() != 0) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL scoreboard_drain pending=%0d expected=0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_control_unit.md
Name: pipeline_control_unit

Overview:
Control and hazard unit that drives the 5-stage pipelined data path's control inputs. It decodes the ID-stage instruction and carries the control bits through internal ID/EX, EX/MEM and MEM/WB control registers. It also generates the EX forwarding selects, the load-use and branch stalls, and the branch redirect/flush. It is the producer of every control signal the data path consumes.

Parameters:
XLEN, 32, instruction width
RW, 5, register-number width

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  reset, synchronous, active-low: registers cleared on posedge clk while rst==0
instrD  in  XLEN  instruction held in the IF/ID register (ID stage)
eqD  in  1  data path register-compare result in ID (rs value == rt value)
regWrite  out  1  WB-stage register-file write enable
regDst  out  1  EX-stage destination select: 1=rd, 0=rt
aluSrcB  out  1  EX-stage ALU B select: 1=immediate, 0=register
aluControl  out  3  EX-stage ALU op: 010 add, 110 sub, 000 and, 001 or, 111 slt
memWrite  out  1  MEM-stage data-memory write enable
mem2Reg  out  1  WB-stage result select: 1=memory, 0=ALU
pcSrc  out  1  ID-stage branch taken: selects branch target for PC
fad  out  2  EX forward select, operand A: 00 regfile, 10 MEM ALU result, 01 WB result
fbd  out  2  EX forward select, operand B: same encoding as fad
flush  out  1  clears IF/ID register on the next edge
stall  out  1  holds PC and IF/ID register on the next edge

Behaviour:
- Decode in ID (combinational from instrD[31:26] op and [5:0] funct):
  - R-type, op 0x00: regWrite=1, regDst=1. funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt. Any other funct decodes as a nop (all controls 0).
  - lw, op 0x23: regWrite=1, aluSrcB=1, mem2Reg=1, add.
  - sw, op 0x2B: memWrite=1, aluSrcB=1, add.
  - beq, op 0x04: branch=1, sub.
  - addi, op 0x08: regWrite=1, aluSrcB=1, add.
  - Any other op: nop (all controls 0).
- Pipelining:
  - ID/EX captures decoded controls plus rs, rt, rd fields.
  - EX computes writeRegE = regDst ? rd : rt. EX/MEM captures regWrite, memWrite, mem2Reg and writeReg; MEM/WB captures regWrite, mem2Reg and writeReg.
  - Latency: an instruction in ID in cycle n presents EX outputs in n+1, memWrite in n+2, and regWrite/mem2Reg in n+3.
- Forwarding (combinational, EX stage):
  - fad=10 if rsE!=0 && regWriteM && writeRegM==rsE.
  - Else fad=01 if rsE!=0 && regWriteW && writeRegW==rsE.
  - Else fad=00. MEM has priority over WB.
  - fbd is computed the same way using rtE.
- Load-use stall: lwStall = mem2RegE && (rtE==rsD || rtE==rtD).
- Branch stall (no branch forwarding): brStall = branchD && ((regWriteE && writeRegE!=0 && writeRegE in {rsD,rtD}) || (mem2RegM && writeRegM!=0 && writeRegM in {rsD,rtD})).
- stall = lwStall | brStall. While stall=1 the ID/EX control registers load all zeros (bubble) and instrD is re-decoded next cycle.
- Branch resolve: pcSrc = branchD & eqD & ~stall; flush = pcSrc.
  - The branch itself proceeds into EX as a nop-write (regWrite=0, memWrite=0).
  - Simultaneous stall and branch: the stall wins and pcSrc=0 that cycle.
- Reset:
  - While rst==0 at posedge, all pipeline control registers clear. Outputs regWrite, regDst, aluSrcB, aluControl, memWrite and mem2Reg are therefore 0 (aluControl 000) after that edge; fad, fbd, stall, pcSrc and flush are 0 given a nop-decoding instrD.
  - Reset mid-stream discards all in-flight instructions; no write enable may be asserted in the cycle after reset.
- Register 0 is never a forwarding or hazard match.

Test Plan:
- Reset: rst=0 for one edge with instructions in flight -> next cycle regWrite=memWrite=mem2Reg=0, aluControl=000, stall=0.
- ALU forward: add $3,$1,$2 (0x00221820), then sub $5,$3,$1 (0x00612822) -> when sub is in EX, fad=10, fbd=00, aluControl=110. One cycle later regWrite=1 with mem2Reg=0 for the add.
- WB forward: add $3,$1,$2, then nop (0x00000000), then sub $5,$3,$1 -> fad=01 when sub is in EX.
- Load-use: lw $2,0($1) (0x8C220000), then add $4,$2,$5 (0x00452020) -> stall=1 for exactly one cycle and the EX controls are all 0. After the stall, fad=01 when add is in EX; lw shows mem2Reg=1, regWrite=1 in WB.
- Branch taken: beq $1,$2 (0x10220004) with eqD=1 and no hazard -> pcSrc=1 and flush=1 in the same cycle; the next EX slot has regWrite=memWrite=0. With eqD=0 -> pcSrc=flush=0.
- Branch hazard: add $3,$1,$2, then beq $3,$1 (0x10610004) with eqD=1 -> stall=1, pcSrc=0 for one cycle, then pcSrc=1 the following cycle. A $0 destination produces no stall.
